// File: rtl/decrip_pkg.sv
// decrip_pkg: shared constants and the inverse code table for the 3-to-5-bit
// symbol decryptor (decrip_rx).
//   CODE_W / DATA_W : encrypted code width and decoded data width
//   C_Dn            : the 5-bit code that carries data value n
//   decode_code()   : maps a 5-bit code to {valid, data}; unknown codes give
//                     valid=0, data=0
package decrip_pkg;

  localparam int unsigned CODE_W = 5;
  localparam int unsigned DATA_W = 3;

  localparam logic [CODE_W-1:0] C_D0 = 5'd6;
  localparam logic [CODE_W-1:0] C_D1 = 5'd5;
  localparam logic [CODE_W-1:0] C_D2 = 5'd10;
  localparam logic [CODE_W-1:0] C_D3 = 5'd16;
  localparam logic [CODE_W-1:0] C_D4 = 5'd1;
  localparam logic [CODE_W-1:0] C_D5 = 5'd8;
  localparam logic [CODE_W-1:0] C_D6 = 5'd11;
  localparam logic [CODE_W-1:0] C_D7 = 5'd20;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
  } decode_t;

  function automatic decode_t decode_code(input logic [CODE_W-1:0] code);
    decode_t r;
    r = '0;
    r.valid = 1'b1;
    case (code)
      C_D0:    r.data = 3'd0;
      C_D1:    r.data = 3'd1;
      C_D2:    r.data = 3'd2;
      C_D3:    r.data = 3'd3;
      C_D4:    r.data = 3'd4;
      C_D5:    r.data = 3'd5;
      C_D6:    r.data = 3'd6;
      C_D7:    r.data = 3'd7;
      default: r.valid = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/decrip_fifo.sv
// decrip_fifo: synchronous FIFO with a registered head word.
//   clk_i   : clock, rising edge
//   rst_ni  : synchronous active-low reset (empties the FIFO)
//   push_i  : write data_i this edge (ignored when full)
//   pop_i   : drop the head entry this edge (ignored when empty)
//   data_i  : write data
//   head_o  : head entry, 0 when empty (register output)
//   valid_o : FIFO not empty (register output)
//   full_o  : FIFO holds DEPTH entries (register output)
// DEPTH must be a power of two so the pointers wrap naturally.
module decrip_fifo
  import decrip_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic             valid_o,
  output logic             full_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             valid_q, valid_d;
  logic             full_q, full_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push  = push_i && !full_q;
    do_pop   = pop_i && valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    valid_d = (cnt_d != '0);
    full_d  = (cnt_d == CW'(DEPTH));
    // Next head: if the slot it lands on is being written this same edge the
    // memory does not hold it yet, so bypass the incoming word.
    head_d = '0;
    if (valid_d) begin
      if (do_push && (wr_ptr_q == rd_ptr_d)) head_d = data_i;
      else                                   head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
      full_q   <= full_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = head_q;
  assign valid_o = valid_q;
  assign full_o  = full_q;

endmodule

// File: rtl/decrip_rx.sv
// decrip_rx: receive-side decoder for the 3-to-5-bit symbol encryptor.
// Decodes each sampled 5-bit code, queues valid results in a FIFO for a
// ready/valid consumer, drops and reports invalid codes, flags overflow.
//   CLK    : clock, rising edge
//   nRST   : synchronous active-low reset
//   Vin    : ECRi valid this cycle
//   ECRi   : encrypted 5-bit code
//   Rdy    : downstream ready
//   Dout   : decoded data at FIFO head (0 when empty)
//   Vout   : Dout valid
//   Full   : FIFO holds DEPTH entries
//   Err    : one-cycle pulse per invalid code sampled on the previous edge
//   Ovf    : sticky, a valid code was lost because the FIFO was full
//   ErrCnt : saturating invalid-code count
// Build option: define DECRIP_ERRCNT_EN to build the ErrCnt counter;
// otherwise ErrCnt is tied to 0.
module decrip_rx
  import decrip_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              Vin,
  input  logic [CODE_W-1:0] ECRi,
  input  logic              Rdy,
  output logic [DATA_W-1:0] Dout,
  output logic              Vout,
  output logic              Full,
  output logic              Err,
  output logic              Ovf,
  output logic [7:0]        ErrCnt
);

  decode_t dec;
  logic    push, lost, bad;
  logic    err_q, err_d;
  logic    ovf_q, ovf_d;

  always_comb begin
    dec   = decode_code(ECRi);
    // Full reflects current occupancy, so a same-cycle pop never makes room.
    push  = Vin && dec.valid && !Full;
    lost  = Vin && dec.valid && Full;
    bad   = Vin && !dec.valid;
    err_d = bad;
    ovf_d = ovf_q | lost;
  end

  decrip_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (nRST),
    .push_i  (push),
    .pop_i   (Rdy),
    .data_i  (dec.data),
    .head_o  (Dout),
    .valid_o (Vout),
    .full_o  (Full)
  );

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      err_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      err_q <= err_d;
      ovf_q <= ovf_d;
    end
  end

  assign Err = err_q;
  assign Ovf = ovf_q;

`ifdef DECRIP_ERRCNT_EN
  logic [7:0] errcnt_q, errcnt_d;

  always_comb begin
    errcnt_d = errcnt_q;
    if (bad && (errcnt_q != '1)) errcnt_d = errcnt_q + 8'd1;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) errcnt_q <= '0;
    else       errcnt_q <= errcnt_d;
  end

  assign ErrCnt = errcnt_q;
`else
  assign ErrCnt = '0;
`endif

endmodule

// File: tb/tb_decrip_rx.sv
module tb_decrip_rx;

  localparam int DEPTH = 4;
`ifdef DECRIP_ERRCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       Vin = 1'b0;
  logic [4:0] ECRi = '0;
  logic       Rdy = 1'b0;
  logic [2:0] Dout;
  logic       Vout, Full, Err, Ovf;
  logic [7:0] ErrCnt;

  decrip_rx #(.DEPTH(DEPTH)) dut (
    .CLK    (CLK),
    .nRST   (nRST),
    .Vin    (Vin),
    .ECRi   (ECRi),
    .Rdy    (Rdy),
    .Dout   (Dout),
    .Vout   (Vout),
    .Full   (Full),
    .Err    (Err),
    .Ovf    (Ovf),
    .ErrCnt (ErrCnt)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Code carried by each data value, indexed by data.
  int code_tab [8] = '{6, 5, 10, 16, 1, 8, 11, 20};

  // Reference model state
  int m_q[$];
  bit m_err;
  bit m_ovf;
  int m_cnt;
  int popped;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic int ref_decode(input int code);
    for (int d = 0; d < 8; d++)
      if (code_tab[d] == code) return d;
    return -1;
  endfunction

  task automatic model_edge(input bit vin, input int code, input bit rdy, input bit rst_n);
    int  d;
    bit  was_full;
    if (!rst_n) begin
      m_q.delete();
      m_err = 0;
      m_ovf = 0;
      m_cnt = 0;
      return;
    end
    d = ref_decode(code);
    was_full = (m_q.size() == DEPTH);
    m_err = vin && (d < 0);
    if (vin && d < 0 && CNT_EN && m_cnt < 255) m_cnt++;
    if (vin && d >= 0 && was_full) m_ovf = 1;
    if (rdy && m_q.size() > 0) begin
      void'(m_q.pop_front());
      popped++;
    end
    if (vin && d >= 0 && !was_full) m_q.push_back(d);
  endtask

  task automatic step(input bit vin, input int code, input bit rdy, input bit rst_n);
    Vin  = vin;
    ECRi = 5'(code);
    Rdy  = rdy;
    nRST = rst_n;
    @(posedge CLK);
    model_edge(vin, code, rdy, rst_n);
    #1;
    check("Vout",   int'(Vout),   int'(m_q.size() > 0));
    check("Dout",   int'(Dout),   (m_q.size() > 0) ? m_q[0] : 0);
    check("Full",   int'(Full),   int'(m_q.size() == DEPTH));
    check("Err",    int'(Err),    int'(m_err));
    check("Ovf",    int'(Ovf),    int'(m_ovf));
    check("ErrCnt", int'(ErrCnt), m_cnt);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 0, rdy, 1);
  endtask

  initial begin
    int p0;
    // Reset state
    step(0, 0, 0, 0);
    step(1, 6, 1, 0);
    check("reset_empty", int'(Vout), 0);

    // All eight codes back-to-back, consumer always ready
    p0 = popped;
    for (int d = 0; d < 8; d++) step(1, code_tab[d], 1, 1);
    idle(2, 1);
    check("seq_drained", popped - p0, 8);

    // Overflow: 5 pushes into a 4-deep FIFO with no consumer
    for (int d = 0; d < 5; d++) step(1, code_tab[d], 0, 1);
    check("ovf_set", int'(Ovf), 1);
    p0 = popped;
    idle(6, 1);
    check("ovf_drain4", popped - p0, 4);

    // Full with simultaneous valid push and pop: pop wins, push lost
    step(0, 0, 0, 0);
    for (int d = 0; d < 4; d++) step(1, code_tab[7 - d], 0, 1);
    step(1, code_tab[2], 1, 1);
    check("full_pushpop_occ3", m_q.size(), 3);
    idle(4, 1);

    // Invalid codes interleaved with a valid one
    step(0, 0, 0, 0);
    step(1, 0, 1, 1);
    step(1, 6, 1, 1);
    step(1, 31, 1, 1);
    step(1, 7, 1, 1);
    step(1, 7, 1, 1);
    idle(3, 1);

    // Counter saturation
    step(0, 0, 0, 0);
    for (int i = 0; i < 300; i++) step(1, 0, $urandom_range(1), 1);
    idle(2, 1);

    // Reset with words queued and a valid code presented
    step(1, 5, 0, 1);
    step(1, 10, 0, 1);
    step(1, 20, 0, 0);
    check("rst_dropped", int'(Vout), 0);
    idle(2, 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int  code;
      bit  rst_n;
      code  = ($urandom_range(9) < 7) ? code_tab[$urandom_range(7)] : int'($urandom_range(31));
      rst_n = ($urandom_range(199) != 0);
      step($urandom_range(3) != 0, code, $urandom_range(2) != 0, rst_n);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
